nibble_serial_subtractor: RTL and testbench
===========================================

// Module: nibble_serial_subtractor
// PURPOSE
//   Multi-cycle subtractor: DIFF = A - B - BIN over WIDTH bits, one 4-bit slice per clock.
//   Complement of the ripple adder chain; shares the datapath ALU's operand buses.
//   Reports borrow and zero/negative/overflow flags.
//   Handshake is START/BUSY/DONE.
// PARAMETERS
//   WIDTH   8   operand width in bits; must be a multiple of 4 (elaboration error otherwise)
//   Derived: SLICES = WIDTH/4, the cycles spent in RUN.
// PORTS
//   CLK    in   1      single clock, rising edge
//   RST    in   1      synchronous, active-high reset
//   START  in   1      request; sampled only in IDLE or DONE state
//   A      in   WIDTH  minuend; captured on the accepting edge
//   B      in   WIDTH  subtrahend; captured on the accepting edge
//   BIN    in   1      borrow-in; captured on the accepting edge
//   BUSY   out  1      high while in RUN
//   DONE   out  1      one-cycle pulse; result outputs are valid from this cycle on
//   DIFF   out  WIDTH  difference, registered
//   BOUT   out  1      borrow-out: 1 iff A < B + BIN (unsigned)
//   ZERO   out  1      DIFF == 0
//   NEG    out  1      DIFF[WIDTH-1]
//   OVF    out  1      signed overflow: A[msb] != B[msb] && DIFF[msb] != A[msb]
// BEHAVIOUR
//   Reset: state IDLE. BUSY, DONE, DIFF, BOUT, ZERO, NEG and OVF are all 0.
//     Operand registers and the slice counter are cleared.
//   States:
//     IDLE -START-> RUN
//     RUN: slice counter k = 0..SLICES-1; when k == SLICES-1 the next state is DONE
//     DONE -START-> RUN (back-to-back accepted); DONE -!START-> IDLE
//   Accepting edge: A, B and BIN are latched; k = 0; borrow register = BIN.
//   Each RUN edge:
//     - slice k of the working difference = A[4k+3:4k] - B[4k+3:4k] - borrow
//     - borrow register takes the slice borrow-out; k increments
//   Final RUN edge (k == SLICES-1): DIFF, BOUT, ZERO, NEG and OVF update together; state goes to DONE.
//   Latency: DONE is high in the cycle after the SLICES-th edge following the accepting edge.
//     WIDTH=8: accept at edge E0, DONE high after E2.
//   Result outputs hold their values until the next operation completes.
//     They do not change during RUN. DIFF is 0 only after reset.
//   START while BUSY: ignored, no queuing. The operands on the bus do not affect the operation in flight.
//   START in the same cycle as DONE: accepted. BUSY rises on the next edge; DONE then falls.
//   RST mid-RUN: abort. Next state is IDLE, all outputs are 0, and no DONE pulse is produced.
//   RST dominates START on the same edge.
//   Arithmetic is modulo 2^WIDTH. BOUT is the final slice's borrow-out; OVF uses the captured A and B MSBs.
// STRUCTURE
//   Shared package sub_pkg:
//     - state enum {IDLE, RUN, DONE}
//     - SLICE_W = 4 localparam
//     - counter width function clog2(SLICES)
//   Sub-module four_bit_subtractor: combinational (A[3:0], B[3:0], BIN -> DIFF[3:0], BOUT).
//     Built from four full-subtractor cells. Exactly one instance, indexed by k.
//   Top level: FSM, slice counter, operand/borrow/result registers, flag logic.
// TESTING (WIDTH=8)
//   0x35 - 0x12, BIN=0 -> DIFF=0x23; BOUT=0; ZERO=0; NEG=0; OVF=0. DONE high after 2nd edge; BUSY high 2 cycles.
//   0x00 - 0x01, BIN=0 -> DIFF=0xFF; BOUT=1; NEG=1; OVF=0.
//   0x80 - 0x01 -> DIFF=0x7F; OVF=1; BOUT=0. Then 0x10 - 0x0F, BIN=1 -> DIFF=0x00; ZERO=1; BOUT=0.
//   START (0x50-0x20) then START (0x01-0x01) one cycle later while BUSY -> DIFF=0x30; exactly one DONE.
//   START asserted in the DONE cycle with 0x09-0x03 -> DONE, BUSY 2 cycles, DONE; DIFF=0x06. No IDLE cycle between.
//   RST at the first RUN edge -> IDLE; every output 0; no DONE within 5 cycles; the next START completes normally.

Source files
------------

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and helpers for the nibble-serial subtractor
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Never returns less than 1 so a single-slice build still gets a legal counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/four_bit_subtractor.sv
// rtl/four_bit_subtractor.sv - combinational 4-bit ripple-borrow subtractor
module four_bit_subtractor (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_bin,
    output logic [3:0] o_diff,
    output logic       o_bout
);

    logic [4:0] w_borrow;

    assign w_borrow[0] = i_bin;

    for (genvar g = 0; g < 4; g++) begin : g_cell
        assign o_diff[g]       = i_a[g] ^ i_b[g] ^ w_borrow[g];
        assign w_borrow[g + 1] = (~i_a[g] & i_b[g]) | (~(i_a[g] ^ i_b[g]) & w_borrow[g]);
    end

    assign o_bout = w_borrow[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle A - B - BIN, one nibble per clock
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf
);

    localparam int SLICES = WIDTH / SLICE_W;
    localparam int CNT_W  = clog2(SLICES);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("nibble_serial_subtractor: WIDTH must be a positive multiple of 4");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_work;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_k;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_zero;
    logic               r_neg;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [SLICE_W-1:0] w_sl_a;
    logic [SLICE_W-1:0] w_sl_b;
    logic [SLICE_W-1:0] w_sl_diff;
    logic               w_sl_bout;
    logic [WIDTH-1:0]   w_work_next;

    // START is only honoured outside RUN, so operands on the bus mid-operation are ignored.
    assign w_accept = i_start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_k == CNT_W'(SLICES - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = RUN;
            RUN:     if (w_last)  w_next_state = DONE;
            DONE:    w_next_state = i_start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_sl_a = '0;
        w_sl_b = '0;
        for (int s = 0; s < SLICES; s++) begin
            if (r_k == CNT_W'(s)) begin
                w_sl_a = r_a[s*SLICE_W +: SLICE_W];
                w_sl_b = r_b[s*SLICE_W +: SLICE_W];
            end
        end
    end

    four_bit_subtractor u_slice (
        .i_a    (w_sl_a),
        .i_b    (w_sl_b),
        .i_bin  (r_borrow),
        .o_diff (w_sl_diff),
        .o_bout (w_sl_bout)
    );

    always_comb begin
        w_work_next = r_work;
        for (int s = 0; s < SLICES; s++) begin
            if (r_k == CNT_W'(s)) begin
                w_work_next[s*SLICE_W +: SLICE_W] = w_sl_diff;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_k      <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a      <= i_a;
                r_b      <= i_b;
                r_borrow <= i_bin;
                r_k      <= '0;
            end else if (r_state == RUN) begin
                r_work   <= w_work_next;
                r_borrow <= w_sl_bout;
                r_k      <= r_k + CNT_W'(1);
                // Results are published together on the last slice so they never show a partial value.
                if (w_last) begin
                    r_diff <= w_work_next;
                    r_bout <= w_sl_bout;
                    r_zero <= (w_work_next == '0);
                    r_neg  <= w_work_next[WIDTH-1];
                    r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                              (w_work_next[WIDTH-1] != r_a[WIDTH-1]);
                end
            end
        end
    end

    assign o_busy = (r_state == RUN);
    assign o_done = (r_state == DONE);
    assign o_diff = r_diff;
    assign o_bout = r_bout;
    assign o_zero = r_zero;
    assign o_neg  = r_neg;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed vector bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;

    int n_vec;
    int n_err;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       neg;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_bin   (bin),
        .o_busy  (busy),
        .o_done  (done),
        .o_diff  (diff),
        .o_bout  (bout),
        .o_zero  (zero),
        .o_neg   (neg),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vbin);
        start = 1'b1;
        a     = va;
        b     = vb;
        bin   = vbin;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, ".diff"}, 32'(diff), 32'(v.diff));
        chk({tag, ".bout"}, 32'(bout), 32'(v.bout));
        chk({tag, ".zero"}, 32'(zero), 32'(v.zero));
        chk({tag, ".neg"},  32'(neg),  32'(v.neg));
        chk({tag, ".ovf"},  32'(ovf),  32'(v.ovf));
    endtask

    initial begin
        int   nbusy;
        bit   seen;
        int   ndone;
        vec_t v;

        n_vec = 0;
        n_err = 0;
        //            a      b      bin   diff   bout  zero  neg   ovf
        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h08, 8'h09, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        v = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        check_result("reset", v);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(nbusy, seen);
            chk($sformatf("vec%0d.done_seen", i), 32'(seen), 32'd1);
            chk($sformatf("vec%0d.busy_cycles", i), 32'(nbusy), 32'd2);
            check_result($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d.done_pulse", i), 32'(done), 32'd0);
        end

        // START while busy: second request must be dropped
        issue(8'h50, 8'h20, 1'b0);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        a     = 8'hAA;
        b     = 8'h55;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                ndone++;
                chk("busy_start.diff", 32'(diff), 32'h30);
            end
            @(negedge clk);
        end
        chk("busy_start.done_count", 32'(ndone), 32'd1);
        chk("busy_start.idle", 32'(busy), 32'd0);

        // back-to-back: START in the DONE cycle
        issue(8'h35, 8'h12, 1'b0);
        wait_done(nbusy, seen);
        chk("b2b.first_done", 32'(seen), 32'd1);
        chk("b2b.first_diff", 32'(diff), 32'h23);
        issue(8'h09, 8'h03, 1'b0);
        chk("b2b.busy1", 32'(busy), 32'd1);
        chk("b2b.done_fell", 32'(done), 32'd0);
        chk("b2b.hold_diff", 32'(diff), 32'h23);
        @(negedge clk);
        chk("b2b.busy2", 32'(busy), 32'd1);
        chk("b2b.hold_diff2", 32'(diff), 32'h23);
        @(negedge clk);
        chk("b2b.second_done", 32'(done), 32'd1);
        chk("b2b.second_diff", 32'(diff), 32'h06);
        @(negedge clk);

        // reset at the first RUN edge
        issue(8'h44, 8'h11, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        v = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        check_result("abort", v);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort.no_done", 32'(ndone), 32'd0);
        issue(8'h44, 8'h11, 1'b0);
        wait_done(nbusy, seen);
        chk("after_abort.done_seen", 32'(seen), 32'd1);
        chk("after_abort.busy_cycles", 32'(nbusy), 32'd2);
        v = '{8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
        check_result("after_abort", v);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
